// File: rtl/framebuffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// framebuffer_write_arbiter
//
// Merges pixel writes from the line-draw accelerator (XL_*) and from the CPU
// MMIO path into the single framebuffer write port. The accelerator has no
// backpressure, so it always wins a cycle. CPU writes are queued in a small
// FIFO and drained in cycles where XL_wr_en is low. Writes whose address lies
// beyond the framebuffer are discarded and reported through a sticky flag.
//
// Ports
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   XL_wr_en/addr/data  accelerator write strobe, address, data (no ready)
//   cpu_wr_valid/ready  CPU write handshake; a write is accepted on valid&ready
//   cpu_wr_addr/data    CPU write address, data
//   fb_wr_en/addr/data  registered framebuffer write port
//   fifo_level          current CPU FIFO occupancy
//   err_oob             sticky out-of-range flag
//   err_clr             clears err_oob; a new out-of-range write takes priority
// -----------------------------------------------------------------------------
module framebuffer_write_arbiter #(
    parameter int mem_width      = 1,
    parameter int mem_depth      = 786432,
    parameter int mem_addr_width = $clog2(mem_depth),
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          XL_wr_en,
    input  logic [mem_addr_width-1:0]     XL_wr_addr,
    input  logic [mem_width-1:0]          XL_wr_data,
    input  logic                          cpu_wr_valid,
    output logic                          cpu_wr_ready,
    input  logic [mem_addr_width-1:0]     cpu_wr_addr,
    input  logic [mem_width-1:0]          cpu_wr_data,
    output logic                          fb_wr_en,
    output logic [mem_addr_width-1:0]     fb_wr_addr,
    output logic [mem_width-1:0]          fb_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_oob,
    input  logic                          err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // One extra bit so mem_depth itself is representable for the range check.
    localparam logic [mem_addr_width:0] ADDR_LIMIT = (mem_addr_width+1)'(mem_depth);
    localparam logic [PTR_W:0]          FULL_LEVEL = (PTR_W+1)'(FIFO_DEPTH);

    logic [mem_addr_width-1:0] fifo_addr [FIFO_DEPTH];
    logic [mem_width-1:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;

    logic                      push;
    logic                      pop;
    logic                      sel_valid;
    logic                      sel_oob;
    logic [mem_addr_width-1:0] sel_addr;
    logic [mem_width-1:0]      sel_data;

    // Ready depends only on the registered level; rst_n only gates it so no
    // request looks accepted while the block is held in reset.
    assign cpu_wr_ready = rst_n && (fifo_level < FULL_LEVEL);
    assign push         = cpu_wr_valid && cpu_wr_ready;

    // Source selection: accelerator first, otherwise the FIFO head.
    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_addr  = XL_wr_addr;
        sel_data  = XL_wr_data;
        if (XL_wr_en) begin
            sel_valid = 1'b1;
        end else if (fifo_level != '0) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_addr  = fifo_addr[rd_ptr];
            sel_data  = fifo_data[rd_ptr];
        end
        // An out-of-range head is still popped; it is just never written.
        sel_oob = sel_valid && ({1'b0, sel_addr} >= ADDR_LIMIT);
    end

    // NOTE: the FIFO storage carries no reset; the pointers and level alone
    // define which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
            err_oob    <= 1'b0;
        end else begin
            // FIFO_DEPTH is a power of two, so natural overflow wraps pointers.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            // Address/data hold their last written values on idle or
            // discarded cycles.
            fb_wr_en <= sel_valid && !sel_oob;
            if (sel_valid && !sel_oob) begin
                fb_wr_addr <= sel_addr;
                fb_wr_data <= sel_data;
            end

            if (sel_oob)      err_oob <= 1'b1;
            else if (err_clr) err_oob <= 1'b0;
        end
    end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_write_arbiter
//
// Directed bench for framebuffer_write_arbiter: reset, accelerator-only
// writes, single CPU write latency, contention with a full FIFO, back-to-back
// CPU writes across pointer wrap, and out-of-range handling of err_oob.
// -----------------------------------------------------------------------------
module tb_framebuffer_write_arbiter;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          XL_wr_en;
    logic [AW-1:0] XL_wr_addr;
    logic [0:0]    XL_wr_data;
    logic          cpu_wr_valid;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr;
    logic [0:0]    cpu_wr_data;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [0:0]    fb_wr_data;
    logic [3:0]    fifo_level;
    logic          err_oob;
    logic          err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    framebuffer_write_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .XL_wr_en     (XL_wr_en),
        .XL_wr_addr   (XL_wr_addr),
        .XL_wr_data   (XL_wr_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .fb_wr_en     (fb_wr_en),
        .fb_wr_addr   (fb_wr_addr),
        .fb_wr_data   (fb_wr_data),
        .fifo_level   (fifo_level),
        .err_oob      (err_oob),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        XL_wr_en     = 1'b0;
        XL_wr_addr   = '0;
        XL_wr_data   = '0;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 20'd55;
        cpu_wr_data  = 1'b1;
        err_clr      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (cpu_wr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready cyc%0d: got %b want 0", i, cpu_wr_ready);
            end
            n_checks++;
            if (fb_wr_en !== 1'b0 || fifo_level !== 4'd0 || err_oob !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d: en=%b lvl=%0d err=%b want 0/0/0",
                         i, fb_wr_en, fifo_level, err_oob);
            end
        end
        n_checks++;
        if (fb_wr_addr !== 20'd0 || fb_wr_data !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fb: addr=%0d data=%b want 0/0", fb_wr_addr, fb_wr_data);
        end
        cpu_wr_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        n_checks++;
        if (cpu_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b want 1", cpu_wr_ready);
        end
        tick();
        n_checks++;
        if (fifo_level !== 4'd0 || fb_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: lvl=%0d en=%b want 0/0", fifo_level, fb_wr_en);
        end
    endtask

    task automatic test_xl_only();
        logic [AW-1:0] exp_addr;
        for (int i = 0; i < 5; i++) begin
            XL_wr_en   = 1'b1;
            XL_wr_addr = 20'(100 + i);
            XL_wr_data = 1'b1;
            tick();
            exp_addr = 20'(100 + i);
            n_checks++;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== exp_addr || fb_wr_data !== 1'b1) begin
                n_fail++;
                $display("FAIL xl_write%0d: en=%b addr=%0d data=%b want 1/%0d/1",
                         i, fb_wr_en, fb_wr_addr, fb_wr_data, exp_addr);
            end
        end
        XL_wr_en = 1'b0;
        tick();
        n_checks++;
        if (fb_wr_en !== 1'b0 || fb_wr_addr !== 20'd104) begin
            n_fail++;
            $display("FAIL xl_idle_hold: en=%b addr=%0d want 0/104", fb_wr_en, fb_wr_addr);
        end
    endtask

    task automatic test_cpu_only();
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 20'd7;
        cpu_wr_data  = 1'b1;
        n_checks++;
        if (cpu_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_ready: got %b want 1", cpu_wr_ready);
        end
        tick();
        cpu_wr_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd1 || fb_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_n1: lvl=%0d en=%b want 1/0", fifo_level, fb_wr_en);
        end
        tick();
        n_checks++;
        if (fb_wr_en !== 1'b1 || fb_wr_addr !== 20'd7 || fb_wr_data !== 1'b1 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL cpu_n2: en=%b addr=%0d data=%b lvl=%0d want 1/7/1/0",
                     fb_wr_en, fb_wr_addr, fb_wr_data, fifo_level);
        end
    endtask

    task automatic test_contention();
        int            pushed = 0;
        logic          exp_ready;
        logic [AW-1:0] exp_addr;
        for (int k = 0; k < 20; k++) begin
            XL_wr_en     = 1'b1;
            XL_wr_addr   = 20'(300 + k);
            XL_wr_data   = 1'(k);
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 20'(pushed);
            cpu_wr_data  = 1'(pushed + 1);
            #1;
            exp_ready = (pushed < 8);
            n_checks++;
            if (cpu_wr_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL cont_ready%0d: got %b want %b", k, cpu_wr_ready, exp_ready);
            end
            if (exp_ready) pushed++;
            tick();
            exp_addr = 20'(300 + k);
            n_checks++;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== exp_addr || fifo_level !== 4'(pushed)) begin
                n_fail++;
                $display("FAIL cont_xl%0d: en=%b addr=%0d lvl=%0d want 1/%0d/%0d",
                         k, fb_wr_en, fb_wr_addr, fifo_level, exp_addr, pushed);
            end
        end
        XL_wr_en     = 1'b0;
        cpu_wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_addr = 20'(i);
            n_checks++;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== exp_addr || fb_wr_data !== 1'(i + 1)) begin
                n_fail++;
                $display("FAIL cont_drain%0d: en=%b addr=%0d data=%b want 1/%0d/%b",
                         i, fb_wr_en, fb_wr_addr, fb_wr_data, exp_addr, 1'(i + 1));
            end
        end
        tick();
        n_checks++;
        if (fb_wr_en !== 1'b0 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL cont_empty: en=%b lvl=%0d want 0/0", fb_wr_en, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                cpu_wr_valid = 1'b1;
                cpu_wr_addr  = 20'(500 + i);
                cpu_wr_data  = 1'(i);
            end else begin
                cpu_wr_valid = 1'b0;
            end
            tick();
            n_checks++;
            if (fifo_level > 4'd1) begin
                n_fail++;
                $display("FAIL b2b_level%0d: got %0d want <=1", i, fifo_level);
            end
            if (i >= 1) begin
                exp_addr = 20'(500 + i - 1);
                n_checks++;
                if (fb_wr_en !== 1'b1 || fb_wr_addr !== exp_addr || fb_wr_data !== 1'(i - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_write%0d: en=%b addr=%0d data=%b want 1/%0d/%b",
                             i - 1, fb_wr_en, fb_wr_addr, fb_wr_data, exp_addr, 1'(i - 1));
                end
            end
        end
        tick();
        n_checks++;
        if (fb_wr_en !== 1'b0 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_end: en=%b lvl=%0d want 0/0", fb_wr_en, fifo_level);
        end
    endtask

    task automatic test_oob();
        // Last legal address is written normally.
        XL_wr_en   = 1'b1;
        XL_wr_addr = 20'd786431;
        XL_wr_data = 1'b1;
        tick();
        n_checks++;
        if (fb_wr_en !== 1'b1 || fb_wr_addr !== 20'd786431 || err_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_edge_ok: en=%b addr=%0d err=%b want 1/786431/0",
                     fb_wr_en, fb_wr_addr, err_oob);
        end
        // First illegal address from the accelerator.
        XL_wr_addr = 20'd786432;
        XL_wr_data = 1'b0;
        tick();
        XL_wr_en = 1'b0;
        n_checks++;
        if (fb_wr_en !== 1'b0 || err_oob !== 1'b1 || fb_wr_addr !== 20'd786431) begin
            n_fail++;
            $display("FAIL oob_xl: en=%b err=%b addr=%0d want 0/1/786431",
                     fb_wr_en, err_oob, fb_wr_addr);
        end
        tick();
        tick();
        n_checks++;
        if (err_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_sticky: got %b want 1", err_oob);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_clr: got %b want 0", err_oob);
        end
        // Out-of-range CPU write: pushed, then popped without a write.
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 20'd786500;
        cpu_wr_data  = 1'b1;
        tick();
        cpu_wr_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd1 || err_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_cpu_push: lvl=%0d err=%b want 1/0", fifo_level, err_oob);
        end
        tick();
        n_checks++;
        if (fb_wr_en !== 1'b0 || fifo_level !== 4'd0 || err_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_cpu_pop: en=%b lvl=%0d err=%b want 0/0/1",
                     fb_wr_en, fifo_level, err_oob);
        end
        err_clr = 1'b1;
        tick();
        n_checks++;
        if (err_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_clr2: got %b want 0", err_oob);
        end
        // Clear and a new violation in the same cycle: set wins.
        XL_wr_en   = 1'b1;
        XL_wr_addr = 20'hFFFFF;
        tick();
        XL_wr_en = 1'b0;
        err_clr  = 1'b0;
        n_checks++;
        if (err_oob !== 1'b1 || fb_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_set_wins: err=%b en=%b want 1/0", err_oob, fb_wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_xl_only();
        test_cpu_only();
        test_contention();
        test_back_to_back();
        test_oob();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
